// File: rtl/sysmon_sweep_reader.sv
// Round-robin DRP reader for the SystemMonitor: averages temperature, VCCINT and
// VCCAUX codes over 2**AVG_LOG2 samples each and raises a hysteretic over-temp alarm.
module sysmon_sweep_reader #(
  parameter int         AVG_LOG2 = 3,
  parameter logic [6:0] ADDR_T   = 7'h00,
  parameter logic [6:0] ADDR_VI  = 7'h01,
  parameter logic [6:0] ADDR_VA  = 7'h02,
  parameter int         SETTLE   = 4,
  parameter int         TIMEOUT  = 1023,
  parameter logic [9:0] ALARM_HI = 10'd800,
  parameter logic [9:0] ALARM_LO = 10'd760
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic [6:0]  o_daddr,
  input  logic        i_drdy,
  input  logic [15:0] i_do_data,
  output logic [9:0]  o_temp_avg,
  output logic [9:0]  o_vint_avg,
  output logic [9:0]  o_vaux_avg,
  output logic        o_avg_valid,
  output logic        o_busy,
  output logic        o_alarm,
  output logic        o_timeout_err,
  output logic [2:0]  o_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET     = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_DISCARD = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  localparam int AW = 10 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [1:0]    r_ch;
  logic [AW-1:0] r_acc_t, r_acc_vi, r_acc_va;
  logic [CW-1:0] r_sample_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [TW-1:0] r_wait_cnt;

  logic [9:0] w_code;
  logic [9:0] w_temp_new;
  logic [6:0] w_addr;
  logic       w_timed_out;
  logic       w_unused;

  assign w_code      = i_do_data[15:6];
  assign w_unused    = ^i_do_data[5:0];
  assign w_temp_new  = r_acc_t[AVG_LOG2 +: 10];
  assign w_timed_out = !i_drdy && (r_wait_cnt == WAIT_LAST);
  assign o_state     = r_state;

  always_comb begin
    w_addr = ADDR_T;
    case (r_ch)
      2'd1:    w_addr = ADDR_VI;
      2'd2:    w_addr = ADDR_VA;
      default: w_addr = ADDR_T;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ch          <= 2'd0;
      r_acc_t       <= '0;
      r_acc_vi      <= '0;
      r_acc_va      <= '0;
      r_sample_cnt  <= '0;
      r_settle_cnt  <= '0;
      r_wait_cnt    <= '0;
      o_daddr       <= ADDR_T;
      o_temp_avg    <= '0;
      o_vint_avg    <= '0;
      o_vaux_avg    <= '0;
      o_avg_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_alarm       <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_avg_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_ch    <= 2'd0;
            o_busy  <= 1'b1;
            r_state <= S_SET;
          end
        end
        S_SET: begin
          o_daddr      <= w_addr;
          r_settle_cnt <= '0;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= S_DISCARD;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_DISCARD, S_CAPTURE: begin
          if (w_timed_out) begin
            // Retry the same channel; samples already accumulated are kept.
            o_timeout_err <= 1'b1;
            r_state       <= S_SET;
          end else if (!i_drdy) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end else begin
            r_wait_cnt <= '0;
            if (r_state == S_DISCARD) begin
              r_state <= S_CAPTURE;
            end else begin
              case (r_ch)
                2'd1:    r_acc_vi <= r_acc_vi + AW'(w_code);
                2'd2:    r_acc_va <= r_acc_va + AW'(w_code);
                default: r_acc_t  <= r_acc_t + AW'(w_code);
              endcase
              if (r_sample_cnt == LAST_SAMPLE) begin
                r_sample_cnt <= '0;
                r_state      <= S_NEXT;
              end else begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
              end
            end
          end
        end
        S_NEXT: begin
          if (r_ch == 2'd2) begin
            o_temp_avg   <= w_temp_new;
            o_vint_avg   <= r_acc_vi[AVG_LOG2 +: 10];
            o_vaux_avg   <= r_acc_va[AVG_LOG2 +: 10];
            o_avg_valid  <= 1'b1;
            if (w_temp_new >= ALARM_HI) begin
              o_alarm <= 1'b1;
            end else if (w_temp_new <= ALARM_LO) begin
              o_alarm <= 1'b0;
            end
            r_acc_t      <= '0;
            r_acc_vi     <= '0;
            r_acc_va     <= '0;
            r_sample_cnt <= '0;
            r_ch         <= 2'd0;
            if (i_enable) begin
              r_state <= S_SET;
            end else begin
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_SET;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmon_sweep_reader.sv
// Bench for sysmon_sweep_reader: a behavioural DRP model feeds per-address codes,
// expected sweep results are queued at stimulus time and compared on avg_valid.
module tb_sysmon_sweep_reader;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        drdy;
  logic [15:0] do_data;
  logic [6:0]  daddr;
  logic [9:0]  temp_avg, vint_avg, vaux_avg;
  logic        avg_valid, busy, alarm, timeout_err;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;

  // {temp, vint, vaux, alarm}
  logic [30:0] exp_q[$];

  typedef struct {
    logic [9:0] t, vi, va;
    bit         alt;
    logic [9:0] et, evi, eva;
    logic       ea;
  } vec_t;

  vec_t vecs[10];

  // DRP model state
  logic [9:0] m_t, m_vi, m_va;
  bit         m_alt, m_par, m_stall, m_tag;
  int         m_cnt;
  logic [6:0] m_seen;

  always #5 clk = ~clk;

  sysmon_sweep_reader dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_daddr(daddr),
    .i_drdy(drdy), .i_do_data(do_data), .o_temp_avg(temp_avg),
    .o_vint_avg(vint_avg), .o_vaux_avg(vaux_avg), .o_avg_valid(avg_valid),
    .o_busy(busy), .o_alarm(alarm), .o_timeout_err(timeout_err), .o_state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: drdy every 5 cycles; the first drdy after an address change is tagged 0xFFC0.
  always @(negedge clk) begin
    logic [9:0] code;
    if (daddr !== m_seen) begin
      m_seen = daddr;
      m_tag  = 1'b1;
    end
    m_cnt = (m_cnt == 4) ? 0 : m_cnt + 1;
    if (m_cnt == 0 && !m_stall) begin
      drdy = 1'b1;
      if (m_tag) begin
        do_data = 16'hFFC0;
        m_tag   = 1'b0;
      end else begin
        case (daddr)
          7'h00: begin
            code = m_t + {9'd0, m_alt & m_par};
            if (m_alt) m_par = ~m_par;
          end
          7'h01:   code = m_vi;
          7'h02:   code = m_va;
          default: code = 10'h3FF;
        endcase
        do_data = {code, 6'h2A};
      end
    end else begin
      drdy    = 1'b0;
      do_data = 16'h0000;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [30:0] e;
    if (avg_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_avg_valid actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk("temp_avg", {22'd0, temp_avg}, {22'd0, e[30:21]});
        chk("vint_avg", {22'd0, vint_avg}, {22'd0, e[20:11]});
        chk("vaux_avg", {22'd0, vaux_avg}, {22'd0, e[10:1]});
        chk("alarm",    {31'd0, alarm},    {31'd0, e[0]});
      end
    end
  end

  task automatic wait_valids(input int n, input int bound);
    int start;
    start = n_valid;
    for (int i = 0; i < bound && n_valid < start + n; i++) @(negedge clk);
    chk("avg_valid_count", n_valid - start, n);
  endtask

  task automatic start_one_sweep();
    int i;
    @(negedge clk);
    enable = 1'b1;
    for (i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    chk("busy_after_enable", {31'd0, busy}, 1);
    enable = 1'b0;
  endtask

  task automatic wait_cap(input logic [6:0] addr, input int bound);
    bit found;
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (state == S_CAPTURE && daddr == addr) found = 1;
    end
    chk("reach_capture", {31'd0, found}, 1);
  endtask

  task automatic set_model(input logic [9:0] t, input logic [9:0] vi,
                           input logic [9:0] va, input bit alt);
    m_t = t; m_vi = vi; m_va = va; m_alt = alt; m_par = 0;
  endtask

  initial begin
    int base;
    bit saw_set, moved;
    logic [6:0] held;

    vecs[0] = '{10'd512,  10'd341, 10'd612,  0, 10'd512,  10'd341, 10'd612,  1'b0};
    vecs[1] = '{10'd100,  10'd341, 10'd612,  1, 10'd100,  10'd341, 10'd612,  1'b0};
    vecs[2] = '{10'd805,  10'd300, 10'd600,  0, 10'd805,  10'd300, 10'd600,  1'b1};
    vecs[3] = '{10'd780,  10'd300, 10'd600,  0, 10'd780,  10'd300, 10'd600,  1'b1};
    vecs[4] = '{10'd760,  10'd300, 10'd600,  0, 10'd760,  10'd300, 10'd600,  1'b0};
    vecs[5] = '{10'd799,  10'd1,   10'd2,    0, 10'd799,  10'd1,   10'd2,    1'b0};
    vecs[6] = '{10'd800,  10'd1,   10'd2,    0, 10'd800,  10'd1,   10'd2,    1'b1};
    vecs[7] = '{10'd761,  10'd1,   10'd2,    0, 10'd761,  10'd1,   10'd2,    1'b1};
    vecs[8] = '{10'd1023, 10'd0,   10'd1023, 0, 10'd1023, 10'd0,   10'd1023, 1'b1};
    vecs[9] = '{10'd0,    10'd341, 10'd612,  0, 10'd0,    10'd341, 10'd612,  1'b0};

    m_cnt = 0; m_stall = 0; m_tag = 0; m_seen = 7'h00;
    set_model(10'd0, 10'd0, 10'd0, 0);
    drdy = 0; do_data = 0;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_daddr", {25'd0, daddr}, 0);
    chk("rst_temp",  {22'd0, temp_avg}, 0);
    chk("rst_vint",  {22'd0, vint_avg}, 0);
    chk("rst_vaux",  {22'd0, vaux_avg}, 0);
    chk("rst_flags", {28'd0, avg_valid, busy, alarm, timeout_err}, 0);
    chk("rst_state", {29'd0, state}, {29'd0, S_IDLE});
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_start", {31'd0, busy}, 0);

    // Table-driven single sweeps
    for (int v = 0; v < 10; v++) begin
      set_model(vecs[v].t, vecs[v].vi, vecs[v].va, vecs[v].alt);
      exp_q.push_back({vecs[v].et, vecs[v].evi, vecs[v].eva, vecs[v].ea});
      start_one_sweep();
      wait_valids(1, 2000);
      chk("busy_end", {31'd0, busy}, 0);
      chk("state_end", {29'd0, state}, {29'd0, S_IDLE});
    end
    chk("no_timeout_yet", {31'd0, timeout_err}, 0);

    // drdy stalls mid-capture on temperature: timeout, retry same channel, recover
    set_model(10'd512, 10'd341, 10'd612, 0);
    exp_q.push_back({10'd512, 10'd341, 10'd612, 1'b0});
    start_one_sweep();
    wait_cap(7'h00, 300);
    m_stall = 1;
    saw_set = 0;
    repeat (1100) begin
      @(negedge clk);
      if (state == S_SET) saw_set = 1;
    end
    chk("timeout_err_set", {31'd0, timeout_err}, 1);
    chk("timeout_retry",   {31'd0, saw_set}, 1);
    chk("timeout_daddr",   {25'd0, daddr}, 0);
    m_stall = 0;
    wait_valids(1, 3000);
    chk("timeout_sticky", {31'd0, timeout_err}, 1);

    // enable dropped during the VCCINT phase
    exp_q.push_back({10'd512, 10'd341, 10'd612, 1'b0});
    @(negedge clk);
    enable = 1'b1;
    wait_cap(7'h01, 500);
    enable = 1'b0;
    wait_valids(1, 2000);
    chk("drop_busy",  {31'd0, busy}, 0);
    chk("drop_state", {29'd0, state}, {29'd0, S_IDLE});
    held = daddr; moved = 0; base = n_valid;
    repeat (200) begin
      @(negedge clk);
      if (daddr != held) moved = 1;
    end
    chk("drop_daddr_still", {31'd0, moved}, 0);
    chk("drop_no_more_valid", n_valid - base, 0);

    // Continuous sweeping: two back-to-back results, alarm raised
    set_model(10'd900, 10'd341, 10'd612, 0);
    exp_q.push_back({10'd900, 10'd341, 10'd612, 1'b1});
    exp_q.push_back({10'd900, 10'd341, 10'd612, 1'b1});
    @(negedge clk);
    enable = 1'b1;
    wait_valids(1, 2000);
    chk("cont_busy", {31'd0, busy}, 1);
    enable = 1'b0;
    wait_valids(1, 2000);
    chk("cont_busy_end", {31'd0, busy}, 0);

    // Reset mid-capture: everything back to reset values, nothing published
    set_model(10'd512, 10'd341, 10'd612, 0);
    @(negedge clk);
    enable = 1'b1;
    wait_cap(7'h01, 500);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_daddr", {25'd0, daddr}, 0);
    chk("mrst_avgs",  {2'd0, temp_avg, vint_avg, vaux_avg}, 0);
    chk("mrst_flags", {28'd0, avg_valid, busy, alarm, timeout_err}, 0);
    chk("mrst_state", {29'd0, state}, {29'd0, S_IDLE});
    enable = 1'b0;
    rst = 1'b0;
    base = n_valid;
    repeat (300) @(negedge clk);
    chk("mrst_no_publish", n_valid - base, 0);

    // Fresh sweep after reset: partial accumulation must not leak in
    exp_q.push_back({10'd512, 10'd341, 10'd612, 1'b0});
    start_one_sweep();
    wait_valids(1, 2000);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
